vectorsum_stream: RTL
=====================

Name: vectorsum_stream

Overview:
- Datapath core of the streaming vector-sum design, sitting between two input FIFOs (x, y) and one output FIFO (z).
- Pops one word from each input FIFO and pushes their sum to the z FIFO. It is the FIFO-reader end for the x/y writers and the FIFO-writer end for the z reader.
- Sustains one element per clock when inputs are available and z is not full.
- Tracks element position within a VECTOR_SIZE-element vector and flags the last element.

Parameters:
- DATA_WIDTH, 32, width of x, y and z words.
- VECTOR_SIZE, 64, elements per vector; sets elem_count wrap and done pulse.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- x_rd_en  out  1  pop x FIFO this cycle
- x_empty  in  1  x FIFO empty
- x_dout  in  DATA_WIDTH  x FIFO head word (first-word-fall-through; valid when x_empty=0)
- y_rd_en  out  1  pop y FIFO this cycle
- y_empty  in  1  y FIFO empty
- y_dout  in  DATA_WIDTH  y FIFO head word (FWFT)
- z_wr_en  out  1  push z_din into z FIFO this cycle
- z_full  in  1  z FIFO full
- z_din  out  DATA_WIDTH  sum word to z FIFO
- elem_count  out  $clog2(VECTOR_SIZE)  index of next element to be written to z
- done  out  1  one-cycle pulse coincident with the z write of element VECTOR_SIZE-1

Behaviour:
- One clock domain. Reset is synchronous and active-high and is sampled on the rising edge of clock.
- Reset values:
  - State is S_LOAD.
  - sum_reg is 0.
  - elem_count is 0.
  - x_rd_en, y_rd_en, z_wr_en and done are all 0.
  - z_din is 0.
- FSM states: S_LOAD (output register empty) and S_HOLD (output register holds a valid sum).
- S_LOAD:
  - If x_empty=0 and y_empty=0: assert x_rd_en=y_rd_en=1 in the same cycle (combinational), capture sum_reg <= x_dout + y_dout, and go to S_HOLD.
  - Otherwise: no pop, stay in S_LOAD.
- S_HOLD:
  - z_din = sum_reg (registered, stable while in S_HOLD).
  - If z_full=1: z_wr_en=0, no pops, hold sum_reg, stay in S_HOLD.
  - If z_full=0: z_wr_en=1.
    - If x_empty=0 and y_empty=0 in the same cycle: pop both, load the new sum, stay in S_HOLD (back-to-back, 1 element/cycle).
    - Otherwise: go to S_LOAD.
- Handshake rules:
  - x_rd_en and y_rd_en are always equal. A pop never occurs unless both inputs are non-empty.
  - The block never asserts z_wr_en while z_full=1.
  - No pop occurs in S_HOLD while z_full=1, so no element is dropped or duplicated.
- Latency: an element popped at edge n is written to z at edge n+1 at the earliest. The first write of a stream occurs one cycle after the first pop.
- Throughput: N elements with no stalls take N+1 cycles from first pop to last write.
- Arithmetic:
  - z = (x + y) mod 2^DATA_WIDTH, unsigned wrap; the carry is discarded.
  - No saturation and no overflow flag.
- Counter:
  - elem_count increments on each z write and wraps from VECTOR_SIZE-1 to 0.
  - done = z_wr_en AND (elem_count == VECTOR_SIZE-1). It is combinational from registered state and lasts exactly one cycle per vector.
- Reset mid-operation: any pending sum in S_HOLD is discarded and not written, and elem_count returns to 0. Words already popped are lost; upstream FIFOs are reset alongside the block.
- Input empty deasserting during S_HOLD+z_full: no action until z_full=0.
- Asymmetric availability (one input empty): no pop from either FIFO.

Test Plan:
- Single element:
  - Stimulus: after reset, x=0x00000001 and y=0x00000002 presented.
  - Required: pop in cycle c, z_wr_en=1 with z_din=0x00000003 in cycle c+1, elem_count then 1, done=0.
- Wrap arithmetic:
  - Stimulus: x=0xFFFFFFFF, y=0x00000002.
  - Required: z_din=0x00000001.
  - Stimulus: x=0x80000000, y=0x80000000.
  - Required: z_din=0x00000000.
- Full stream:
  - Stimulus: 64 elements from x.txt/y.txt, FIFOs pre-filled, z_full never asserted.
  - Required: 64 writes in 64 consecutive cycles starting one cycle after the first pop, all matching z.txt, done pulses once on the 64th write, elem_count returns to 0.
- Backpressure:
  - Stimulus: z_full held high for 5 cycles mid-stream at element 10.
  - Required: z_wr_en=0, x_rd_en=y_rd_en=0, z_din frozen at element 10 sum; after release the stream resumes with no loss or duplicate and the total is still 64 matching writes.
- Starvation / asymmetry:
  - Stimulus: y_empty=1 for 4 cycles while x non-empty.
  - Required: no pops on either FIFO, pending sum written once, FSM in S_LOAD until y has data.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle while in S_HOLD with z_full=1 at element 20.
  - Required: held sum never written, elem_count=0, all outputs 0 the cycle after reset; a subsequent fresh 64-element vector passes with done at its 64th write.

Source files
------------

// File: rtl/vectorsum_stream.sv
// vectorsum_stream: pops one word from each of the x/y FIFOs, adds them, and
// pushes the sum to the z FIFO at up to one element per clock. It also tracks
// the element position inside a VECTOR_SIZE-element vector and flags the last one.
module vectorsum_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 64,
  localparam int CNT_W      = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  x_rd_en,
  input  logic                  x_empty,
  input  logic [DATA_WIDTH-1:0] x_dout,
  output logic                  y_rd_en,
  input  logic                  y_empty,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic                  z_wr_en,
  input  logic                  z_full,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic [CNT_W-1:0]      elem_count,
  output logic                  done
);

  typedef enum logic {
    S_LOAD,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_SIZE - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    both_avail;
  logic                    pop_en;
  logic                    wr_en;

  // Next-state logic: decide pop/write for this cycle and the resulting register updates.
  always_comb begin
    both_avail = !x_empty && !y_empty;
    pop_en     = 1'b0;
    wr_en      = 1'b0;
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;

    unique case (state_q)
      S_LOAD: begin
        if (both_avail) begin
          pop_en  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!z_full) begin
          wr_en = 1'b1;
          if (both_avail) begin
            pop_en = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (pop_en) begin
      sum_d = x_dout + y_dout;
    end

    if (wr_en) begin
      count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
    end
  end

  // State, pending sum and element counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_LOAD;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  // Handshakes are suppressed while reset is held so no word is popped or pushed
  // into FIFOs that are being reset alongside this block.
  assign x_rd_en    = pop_en && !reset;
  assign y_rd_en    = pop_en && !reset;
  assign z_wr_en    = wr_en && !reset;
  assign z_din      = sum_q;
  assign elem_count = count_q;
  assign done       = wr_en && !reset && (count_q == LAST_IDX);

endmodule
